ntt_stage_sched: RTL and testbench

- Sequencer for the butterfly datapath: walks a full N-point Cooley-Tukey NTT, one butterfly per cycle.
- Issues coefficient-memory read address pairs and the twiddle (zeta) ROM index.
- Tracks in-flight butterflies through the fixed-latency read+butterfly pipeline and emits matching write-back addresses.
- Inserts a pipeline drain between stages so no stage reads data still in flight from the previous stage.

---
 rtl/ntt_stage_sched.sv | 153 +++++++++++++++
 tb/tb_ntt_stage_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ntt_stage_sched.sv
// Butterfly sequencer for an N-point NTT: issues read pairs and twiddle indices and returns write-backs PIPE_LAT cycles later.
// Optional macro NTT_STAGE_SCHED_INTT_EN adds inv_i for Gentleman-Sande inverse ordering.
module ntt_stage_sched #(
   parameter int N        = 256,
   parameter int PIPE_LAT = 3,
   localparam int LOG_N   = $clog2(N),
   localparam int SW      = $clog2(LOG_N) + 1
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic             stall_i,
`ifdef NTT_STAGE_SCHED_INTT_EN
   input  logic             inv_i,
`endif
   output logic             busy_o,
   output logic             done_o,
   output logic             rd_valid_o,
   output logic [LOG_N-1:0] rd_addr_a_o,
   output logic [LOG_N-1:0] rd_addr_b_o,
   output logic [LOG_N-1:0] zeta_idx_o,
   output logic             wr_valid_o,
   output logic [LOG_N-1:0] wr_addr_a_o,
   output logic [LOG_N-1:0] wr_addr_b_o,
   output logic [SW-1:0]    stage_o
);

   localparam int DW = $clog2(PIPE_LAT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state_q, state_d;
   logic              issue, last_issue, drain_end, inv_start;
   logic              inv_q;
   logic [SW-1:0]     s_q;
   logic [DW-1:0]     dcnt_q;
   logic [LOG_N-1:0]  len_q, off_q, a_q, b_q, k_q;

`ifdef NTT_STAGE_SCHED_INTT_EN
   assign inv_start = inv_i;
`else
   assign inv_start = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      last_issue = 1'b0;
      drain_end  = 1'b0;
      case (state_q)
         IDLE:  if (start_i) state_d = ISSUE;
         ISSUE: begin
            if (!stall_i) begin
               issue = 1'b1;
               // The final butterfly of every stage (either ordering) writes the top word.
               if (b_q == LOG_N'(N - 1)) begin
                  last_issue = 1'b1;
                  state_d    = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (dcnt_q == DW'(PIPE_LAT - 1)) begin
               drain_end = 1'b1;
               state_d   = (s_q == SW'(LOG_N - 1)) ? DONE : ISSUE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address registers hold the next butterfly to issue and stay put once a stage's last one has gone.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         inv_q  <= 1'b0;
         s_q    <= '0;
         dcnt_q <= '0;
         len_q  <= '0;
         off_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         k_q    <= '0;
      end else begin
         dcnt_q <= (state_q == DRAIN) ? dcnt_q + DW'(1) : '0;
         if (state_q == IDLE && start_i) begin
            inv_q <= inv_start;
            s_q   <= '0;
            off_q <= '0;
            a_q   <= '0;
            len_q <= inv_start ? LOG_N'(1) : LOG_N'(N / 2);
            b_q   <= inv_start ? LOG_N'(1) : LOG_N'(N / 2);
            k_q   <= inv_start ? LOG_N'(N - 1) : LOG_N'(1);
         end else if (issue && !last_issue) begin
            if (off_q == len_q - LOG_N'(1)) begin
               off_q <= '0;
               a_q   <= a_q + len_q + LOG_N'(1);
               b_q   <= b_q + len_q + LOG_N'(1);
               k_q   <= inv_q ? k_q - LOG_N'(1) : k_q + LOG_N'(1);
            end else begin
               off_q <= off_q + LOG_N'(1);
               a_q   <= a_q + LOG_N'(1);
               b_q   <= b_q + LOG_N'(1);
            end
         end else if (drain_end && s_q != SW'(LOG_N - 1)) begin
            s_q   <= s_q + SW'(1);
            off_q <= '0;
            a_q   <= '0;
            len_q <= inv_q ? len_q << 1 : len_q >> 1;
            b_q   <= inv_q ? len_q << 1 : len_q >> 1;
            // Stage start zeta is one step past the previous stage's last group in both orderings.
            k_q   <= inv_q ? k_q - LOG_N'(1) : k_q + LOG_N'(1);
         end
      end
   end

   logic [PIPE_LAT-1:0]            vld_pipe;
   logic [PIPE_LAT-1:0][LOG_N-1:0] wa_pipe, wb_pipe;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         vld_pipe <= '0;
         wa_pipe  <= '0;
         wb_pipe  <= '0;
      end else begin
         vld_pipe[0] <= issue;
         wa_pipe[0]  <= a_q;
         wb_pipe[0]  <= b_q;
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            wa_pipe[i]  <= wa_pipe[i-1];
            wb_pipe[i]  <= wb_pipe[i-1];
         end
      end
   end

   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign rd_valid_o  = issue;
   assign rd_addr_a_o = a_q;
   assign rd_addr_b_o = b_q;
   assign zeta_idx_o  = k_q;
   assign stage_o     = s_q;
   assign wr_valid_o  = vld_pipe[PIPE_LAT-1];
   assign wr_addr_a_o = wa_pipe[PIPE_LAT-1];
   assign wr_addr_b_o = wb_pipe[PIPE_LAT-1];

endmodule

// File: tb/tb_ntt_stage_sched.sv
// Directed bench for ntt_stage_sched: N=8 sequences/timing/stall/reset/busy-start, plus a default N=256 full run.
module tb_ntt_stage_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, start, stall, inv;
   logic       busy, done, rd_valid, wr_valid;
   logic [2:0] rd_a, rd_b, zeta, wr_a, wr_b, stage;

   logic       start_l;
   logic       busy_l, done_l, rd_valid_l, wr_valid_l;
   logic [7:0] rd_a_l, rd_b_l, zeta_l, wr_a_l, wr_b_l;
   logic [3:0] stage_l;

   ntt_stage_sched #(.N(8), .PIPE_LAT(3)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .stall_i(stall),
`ifdef NTT_STAGE_SCHED_INTT_EN
      .inv_i(inv),
`endif
      .busy_o(busy), .done_o(done), .rd_valid_o(rd_valid),
      .rd_addr_a_o(rd_a), .rd_addr_b_o(rd_b), .zeta_idx_o(zeta),
      .wr_valid_o(wr_valid), .wr_addr_a_o(wr_a), .wr_addr_b_o(wr_b), .stage_o(stage)
   );

   ntt_stage_sched dut_l (
      .clk_i(clk), .reset_i(reset), .start_i(start_l), .stall_i(1'b0),
`ifdef NTT_STAGE_SCHED_INTT_EN
      .inv_i(1'b0),
`endif
      .busy_o(busy_l), .done_o(done_l), .rd_valid_o(rd_valid_l),
      .rd_addr_a_o(rd_a_l), .rd_addr_b_o(rd_b_l), .zeta_idx_o(zeta_l),
      .wr_valid_o(wr_valid_l), .wr_addr_a_o(wr_a_l), .wr_addr_b_o(wr_b_l), .stage_o(stage_l)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // hand-derived N=8 butterfly tables
   int fa[12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
   int fb[12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
   int fk[12] = '{1,1,1,1, 2,2,3,3, 4,5,6,7};
   int ia[12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
   int ib[12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
   int ik[12] = '{7,6,5,4, 3,3,2,2, 1,1,1,1};
   int ic_tbl[12] = '{1,2,3,4, 8,9,10,11, 15,16,17,18};
   int wc_tbl[12] = '{4,5,6,7, 11,12,13,14, 18,19,20,21};
   int st_tbl[12] = '{0,0,0,0, 1,1,1,1, 2,2,2,2};

   int q_ic[$], q_ia[$], q_ib[$], q_ik[$], q_is[$];
   int q_wc[$], q_wa[$], q_wb[$], q_dc[$], q_busy[$];

   task automatic run8(input int ncyc, input int stall_lo, input int stall_hi,
                       input int start2, input int rst_cyc, input int start3, input logic inv_v);
      q_ic.delete(); q_ia.delete(); q_ib.delete(); q_ik.delete(); q_is.delete();
      q_wc.delete(); q_wa.delete(); q_wb.delete(); q_dc.delete(); q_busy.delete();
      for (int c = 0; c < ncyc; c++) begin
         start = (c == 0 || c == start2 || c == start3);
         stall = (c >= stall_lo && c <= stall_hi);
         reset = (c == rst_cyc);
         inv   = inv_v;
         #1;
         if (rd_valid) begin
            q_ic.push_back(c); q_ia.push_back(int'(rd_a)); q_ib.push_back(int'(rd_b));
            q_ik.push_back(int'(zeta)); q_is.push_back(int'(stage));
         end
         if (wr_valid) begin
            q_wc.push_back(c); q_wa.push_back(int'(wr_a)); q_wb.push_back(int'(wr_b));
         end
         if (done) q_dc.push_back(c);
         q_busy.push_back(int'(busy));
         @(negedge clk);
      end
      start = 1'b0; stall = 1'b0; reset = 1'b0;
   endtask

   task automatic check_seq(input string tag, input int base, input bit invm);
      check({tag, " issue_count"}, q_ia.size() - base, 12);
      for (int i = 0; i < 12 && base + i < q_ia.size(); i++) begin
         check($sformatf("%s a[%0d]", tag, i), q_ia[base+i], invm ? ia[i] : fa[i]);
         check($sformatf("%s b[%0d]", tag, i), q_ib[base+i], invm ? ib[i] : fb[i]);
         check($sformatf("%s k[%0d]", tag, i), q_ik[base+i], invm ? ik[i] : fk[i]);
      end
   endtask

   task automatic check_done(input string tag, input int exp_cyc);
      check({tag, " done_count"}, q_dc.size(), 1);
      if (q_dc.size() > 0) check({tag, " done_cycle"}, q_dc[0], exp_cyc);
   endtask

   initial begin
      int n_iss, l_a, l_b, l_k, f_a, f_b, f_k, d_cyc, wr_in_gap;
      reset = 1'b1; start = 1'b0; stall = 1'b0; inv = 1'b0; start_l = 1'b0;
      @(negedge clk); @(negedge clk);
      #1;
      check("rst busy", int'(busy), 0);
      check("rst done", int'(done), 0);
      check("rst rd_valid", int'(rd_valid), 0);
      check("rst wr_valid", int'(wr_valid), 0);
      check("rst addrs", int'({rd_a, rd_b, zeta, wr_a, wr_b}), 0);
      check("rst stage", int'(stage), 0);
      check("rst big rd_b", int'(rd_b_l), 0);
      reset = 1'b0;
      @(negedge clk);

      // plain forward run
      run8(26, -1, -1, -1, -1, -1, 1'b0);
      check_seq("fwd", 0, 1'b0);
      for (int i = 0; i < 12 && i < q_ic.size(); i++) begin
         check($sformatf("fwd issue_cyc[%0d]", i), q_ic[i], ic_tbl[i]);
         check($sformatf("fwd stage[%0d]", i), q_is[i], st_tbl[i]);
      end
      check("fwd wr_count", q_wc.size(), 12);
      for (int i = 0; i < 12 && i < q_wc.size(); i++) begin
         check($sformatf("fwd wr_cyc[%0d]", i), q_wc[i], wc_tbl[i]);
         check($sformatf("fwd wr_a[%0d]", i), q_wa[i], fa[i]);
         check($sformatf("fwd wr_b[%0d]", i), q_wb[i], fb[i]);
      end
      check_done("fwd", 22);
      check("fwd busy@0", q_busy[0], 0);
      check("fwd busy@1", q_busy[1], 1);
      check("fwd busy@22", q_busy[22], 1);
      check("fwd busy@23", q_busy[23], 0);

      // stall on cycles 2-3
      run8(28, 2, 3, -1, -1, -1, 1'b0);
      check_seq("stall", 0, 1'b0);
      if (q_ic.size() > 1) check("stall 2nd issue cyc", q_ic[1], 4);
      check_done("stall", 24);

      // start while busy is ignored
      run8(26, -1, -1, 5, -1, -1, 1'b0);
      check_seq("rebusy", 0, 1'b0);
      check_done("rebusy", 22);

      // reset mid-stage, restart at cycle 10
      run8(36, -1, -1, -1, 6, 10, 1'b0);
      wr_in_gap = 0;
      foreach (q_wc[i]) if (q_wc[i] >= 7 && q_wc[i] <= 10) wr_in_gap++;
      check("rst_mid wr in 7..10", wr_in_gap, 0);
      check("rst_mid busy@7", q_busy[7], 0);
      if (q_ic.size() > 4) check("rst_mid restart cyc", q_ic[4], 11);
      check_seq("rst_mid", 4, 1'b0);
      check_done("rst_mid", 32);

`ifdef NTT_STAGE_SCHED_INTT_EN
      run8(26, -1, -1, -1, -1, -1, 1'b1);
      check_seq("inv", 0, 1'b1);
      check_done("inv", 22);
`endif

      // default N=256 full transform
      n_iss = 0; d_cyc = -1;
      l_a = -1; l_b = -1; l_k = -1; f_a = -1; f_b = -1; f_k = -1;
      for (int c = 0; c < 1060; c++) begin
         start_l = (c == 0);
         #1;
         if (rd_valid_l) begin
            if (n_iss == 0) begin f_a = int'(rd_a_l); f_b = int'(rd_b_l); f_k = int'(zeta_l); end
            l_a = int'(rd_a_l); l_b = int'(rd_b_l); l_k = int'(zeta_l);
            n_iss++;
         end
         if (done_l && d_cyc < 0) d_cyc = c;
         @(negedge clk);
      end
      start_l = 1'b0;
      check("n256 issues", n_iss, 1024);
      check("n256 done_cycle", d_cyc, 1049);
      check("n256 first a", f_a, 0);
      check("n256 first b", f_b, 128);
      check("n256 first k", f_k, 1);
      check("n256 last a", l_a, 254);
      check("n256 last b", l_b, 255);
      check("n256 last k", l_k, 255);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
